// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin arbiter sharing one data-memory port between
//               NUM_HARTS load/store units. One winner is latched per cycle
//               and driven to memory from registers on the following cycle,
//               together with a one-hot acknowledge and the read data.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int NUM_HARTS = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_HARTS-1:0]    i_req_valid,
    input  logic [NUM_HARTS-1:0]    i_req_wen,
    input  logic [NUM_HARTS*32-1:0] i_req_addr,
    input  logic [NUM_HARTS*32-1:0] i_req_wdata,
    input  logic [NUM_HARTS*4-1:0]  i_req_mask,
    output logic [NUM_HARTS-1:0]    o_req_ack,
    output logic [31:0]             o_req_rdata,
    output logic [31:0]             o_dmem_addr,
    output logic                    o_dmem_ren,
    output logic                    o_dmem_wen,
    output logic [31:0]             o_dmem_wdata,
    output logic [3:0]              o_dmem_mask,
    input  logic [31:0]             i_dmem_rdata
);

    localparam int c_GW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUSY = 1'b1;

    logic [0:0]      r_state;
    logic [c_GW-1:0] r_grant;
    logic [c_GW-1:0] r_ptr;
    logic            r_wen;
    logic [29:0]     r_addr_word;
    logic [31:0]     r_wdata;
    logic [3:0]      r_mask;

    logic [NUM_HARTS-1:0] w_gmask;
    logic [NUM_HARTS-1:0] w_elig;
    logic                 w_found;
    logic [c_GW-1:0]      w_win;
    logic [c_GW:0]        w_pos;
    logic [c_GW-1:0]      w_next_ptr;
    logic                 w_sel_wen;
    logic [29:0]          w_sel_addr_word;
    logic [31:0]          w_sel_wdata;
    logic [3:0]           w_sel_mask;

    // Byte-offset bits are the hart's concern; the arbiter only discards them.
    logic [2*NUM_HARTS-1:0] w_unused_addr_lsb;
    logic                   w_unused_bits;

    generate
        for (genvar k = 0; k < NUM_HARTS; k++) begin : g_addr_lsb
            assign w_unused_addr_lsb[2*k +: 2] = i_req_addr[32*k +: 2];
        end
    endgenerate

    assign w_unused_bits = ^w_unused_addr_lsb;

    // One-hot decode of the current grant, used both for masking and for the ack.
    always_comb begin
        w_gmask = '0;
        for (int k = 0; k < NUM_HARTS; k++) begin
            w_gmask[k] = (r_grant == c_GW'(k));
        end
    end

    // The granted hart still holds valid during its ack cycle, so drop it while busy.
    always_comb begin
        w_elig = i_req_valid;
        if (r_state == c_ST_BUSY) begin
            w_elig = i_req_valid & ~w_gmask;
        end
    end

    // Round-robin scan: first eligible hart at or after the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_pos   = '0;
        for (int d = 0; d < NUM_HARTS; d++) begin
            w_pos = {1'b0, r_ptr} + (c_GW+1)'(d);
            if (w_pos >= (c_GW+1)'(NUM_HARTS)) begin
                w_pos = w_pos - (c_GW+1)'(NUM_HARTS);
            end
            for (int k = 0; k < NUM_HARTS; k++) begin
                if (!w_found && w_elig[k] && (w_pos == (c_GW+1)'(k))) begin
                    w_found = 1'b1;
                    w_win   = c_GW'(k);
                end
            end
        end
    end

    // Pointer moves to the hart just after the winner.
    always_comb begin
        if (w_win == c_GW'(NUM_HARTS - 1)) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = w_win + c_GW'(1);
        end
    end

    // Multiplex the winning hart's request fields.
    always_comb begin
        w_sel_wen       = 1'b0;
        w_sel_addr_word = '0;
        w_sel_wdata     = '0;
        w_sel_mask      = '0;
        for (int k = 0; k < NUM_HARTS; k++) begin
            if (w_win == c_GW'(k)) begin
                w_sel_wen       = i_req_wen[k];
                w_sel_addr_word = i_req_addr[32*k+2 +: 30];
                w_sel_wdata     = i_req_wdata[32*k +: 32];
                w_sel_mask      = i_req_mask[4*k +: 4];
            end
        end
    end

    // State, grant, pointer and access registers; request fields sampled only here.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= c_ST_IDLE;
            r_grant     <= '0;
            r_ptr       <= '0;
            r_wen       <= 1'b0;
            r_addr_word <= '0;
            r_wdata     <= '0;
            r_mask      <= '0;
        end else if (w_found) begin
            r_state     <= c_ST_BUSY;
            r_grant     <= w_win;
            r_ptr       <= w_next_ptr;
            r_wen       <= w_sel_wen;
            r_addr_word <= w_sel_addr_word;
            r_wdata     <= w_sel_wdata;
            r_mask      <= w_sel_mask;
        end else begin
            r_state     <= c_ST_IDLE;
        end
    end

    // Drive memory and the acknowledge only while an access is in flight.
    always_comb begin
        o_req_ack    = '0;
        o_req_rdata  = '0;
        o_dmem_addr  = '0;
        o_dmem_ren   = 1'b0;
        o_dmem_wen   = 1'b0;
        o_dmem_wdata = '0;
        o_dmem_mask  = '0;
        if (r_state == c_ST_BUSY) begin
            o_req_ack    = w_gmask;
            o_req_rdata  = i_dmem_rdata;
            o_dmem_addr  = {r_addr_word, 2'b00};
            o_dmem_ren   = ~r_wen;
            o_dmem_wen   = r_wen;
            o_dmem_wdata = r_wdata;
            o_dmem_mask  = r_mask;
        end
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Round-robin arbiter that shares the single data memory port between NUM_HARTS hart load/store units in the multi-core build. Each hart presents a held request; the arbiter latches one winner per cycle, drives the shared dmem interface from registered request fields the following cycle, and returns an acknowledge with read data to that hart. Sits between the harts' dmem outputs and the dmem model.

## Interface

Parameters:
- NUM_HARTS, default 3: number of requesters; valid range 2..8.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_req_valid  in  NUM_HARTS  per-hart request; held until that hart's o_req_ack.
- i_req_wen  in  NUM_HARTS  per-hart 1 = store, 0 = load.
- i_req_addr  in  NUM_HARTS*32  per-hart byte address; hart k occupies bits [32k+31:32k].
- i_req_wdata  in  NUM_HARTS*32  per-hart store data, already lane-shifted.
- i_req_mask  in  NUM_HARTS*4  per-hart byte mask.
- o_req_ack  out  NUM_HARTS  one-hot; bit k high for exactly one cycle when hart k's access is performed.
- o_req_rdata  out  32  read data; valid for the acked hart when its request was a load.
- o_dmem_addr  out  32  word-aligned address to memory.
- o_dmem_ren  out  1  memory read enable.
- o_dmem_wen  out  1  memory write enable.
- o_dmem_wdata  out  32  memory write data.
- o_dmem_mask  out  4  memory byte mask.
- i_dmem_rdata  in  32  memory read data (combinational).

## Operation

- States: IDLE (no access in flight) and BUSY (latched access driven to memory this cycle).
- Registers: state, grant index g (log2 NUM_HARTS bits), latched wen/addr/wdata/mask, round-robin pointer p.
- Eligible set: in IDLE, all k with i_req_valid[k]. In BUSY, the same set with bit g removed, because hart g's valid is still high during its ack cycle.
- Winner is the first eligible index scanning p, p+1, ..., wrapping modulo NUM_HARTS.
- IDLE, eligible set empty: stay IDLE.
- IDLE or BUSY, eligible set non-empty:
  - latch the winner's fields into the access registers;
  - set g to the winner and p to (winner+1) mod NUM_HARTS;
  - next state BUSY.
- BUSY, eligible set empty: next state IDLE.
- BUSY outputs:
  - o_dmem_addr = {addr[31:2],2'b00}.
  - o_dmem_wen = latched wen; o_dmem_ren = ~latched wen. The two are never high together.
  - o_dmem_wdata and o_dmem_mask come from the latched fields.
  - o_req_ack = one-hot(g); o_req_rdata = i_dmem_rdata.
- IDLE outputs: ren, wen and o_req_ack all 0; addr, wdata, mask and rdata are 0.
- Request fields are sampled only at the latch edge. Changing or dropping a request after it is latched does not cancel the access.
- Misalignment checks, load extension and lane selection belong to the hart; the arbiter only forces addr[1:0] to 0.

## Timing

- Reset: state IDLE, p = 0, g = 0, latched fields 0. All outputs are 0 on the cycle after the reset edge.
- Reset asserted while BUSY: no ack on the following cycle. The in-flight access is dropped; a write already presented completes at that edge per the memory model.
- Latency: request high in cycle n while idle → memory access and ack in cycle n+1.
- A load's data is available combinationally in the ack cycle; a store commits at the end of the ack cycle.
- Throughput: with two or more harts continuously requesting, one access per cycle with no idle gaps.
- A single hart that re-asserts immediately after its ack gets at most one access every 2 cycles, because it is excluded during its own ack cycle.
- Fairness: a requesting hart waits at most NUM_HARTS-1 grants to other harts before being served.
- Simultaneous events: lowest index at or after p wins. Requests arriving during BUSY compete in that same cycle.

## Test plan

- Single load: hart 1 requests ren at addr 0x00001006 with mask 1100, memory word 0xAABBCCDD. Next cycle: o_dmem_addr = 0x00001004, ren = 1, o_req_ack = 010, o_req_rdata = 0xAABBCCDD.
- Three-way contention from reset: all harts request in cycle 0, each dropping after its ack. Acks are 001, 010, 100 in cycles 1, 2, 3; cycle 4 is IDLE with no ack.
- Rotation: after hart 0 wins, harts 0 and 2 request together. Hart 2 is granted first, then hart 0.
- Write then read: hart 0 stores 0x12345678, mask 1111, at 0x40; hart 2 then loads 0x40. Hart 2's ack returns 0x12345678, and wen/ren are never both high in any cycle.
- Reset mid-operation: assert i_rst in a BUSY cycle with hart 1 pending. The next cycle has o_req_ack = 0 and state IDLE; hart 1 is granted one cycle after reset deasserts.
- Fairness soak: random requests held until ack for 10k cycles. No hart waits more than 2 grants, and there is exactly one ack per latched request.
